// File: rtl/mmcm_seq_pkg.sv
// Shared types and constants for the MMCM chain sequencer.
package mmcm_seq_pkg;

  localparam int STATE_W    = 3;
  localparam int MAX_STAGES = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    FAULT   = 3'd4
  } state_t;

  // Reset level for stage i while the sequencer is in state s working on stage k.
  function automatic logic stage_in_reset(state_t s, logic [2:0] k, int i);
    logic r;
    case (s)
      HOLD:    r = (i >= int'(k));
      RELEASE: r = (i > int'(k));
      RUN:     r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mmcm_seq_ctrl_sync_bits.sv
// sync_bits: WIDTH-bit two-flop synchroniser with asynchronous active-low reset.
module sync_bits #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_meta;
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/mmcm_seq_ctrl.sv
// mmcm_seq_ctrl: brings up NUM_STAGES cascaded MMCMs one at a time behind the mclk MMCM.
// Optional lock-loss counter output loss_cnt when MMCM_SEQ_LOSS_CNT_EN is defined.
//
// state   | meaning
// IDLE    | all stages in reset, qualifying upstream lock for HOLDOFF_CYCLES
// HOLD    | stage k and above in reset, holdoff window before releasing k
// RELEASE | stage k released, waiting for its lock or the timeout
// RUN     | every stage locked, all_locked high
// FAULT   | retries exhausted on a stage, everything in reset until clear_fault
module mmcm_seq_ctrl
  import mmcm_seq_pkg::*;
#(
  parameter int  NUM_STAGES     = 2,
  parameter int  HOLDOFF_CYCLES = 15,
  parameter int  LOCK_TIMEOUT   = 65535,
  parameter int  MAX_RETRIES    = 3,
  localparam int RETRY_W        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic                  upstream_locked,
  input  logic [NUM_STAGES-1:0] locked_in,
  input  logic                  clear_fault,
  output logic [NUM_STAGES-1:0] mmcm_rst,
  output logic                  all_locked,
  output logic                  fault,
  output logic [2:0]            stage_idx,
  output logic [RETRY_W-1:0]    retry_cnt,
  output logic [STATE_W-1:0]    state
`ifdef MMCM_SEQ_LOSS_CNT_EN
  ,
  output logic [15:0]           loss_cnt
`endif
);

  localparam int                 HOLD_W     = $clog2(HOLDOFF_CYCLES + 1);
  localparam int                 TMO_W      = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [2:0]         LAST_STAGE = 3'(NUM_STAGES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  logic [NUM_STAGES:0]   w_sync;
  logic                  w_ul;
  logic [MAX_STAGES-1:0] w_lk;

  state_t                r_state;
  logic [2:0]            r_stage;
  logic [RETRY_W-1:0]    r_retry;
  logic                  r_fault;
  logic                  r_all_locked;
  logic [NUM_STAGES-1:0] r_mmcm_rst;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [TMO_W-1:0]      r_tmo_cnt;

  state_t                w_state_nxt;
  logic [2:0]            w_stage_nxt;
  logic [RETRY_W-1:0]    w_retry_nxt;
  logic                  w_fault_nxt;
  logic [HOLD_W-1:0]     w_hold_nxt;
  logic [TMO_W-1:0]      w_tmo_nxt;
  logic [NUM_STAGES-1:0] w_rst_nxt;
  logic                  w_lost;
  logic [2:0]            w_lost_idx;
  logic [3:0]            w_lost_lim;

  sync_bits #(
    .WIDTH (NUM_STAGES + 1)
  ) u_sync (
    .i_clk   (mclk),
    .i_rst_n (rst_n),
    .i_d     ({locked_in, upstream_locked}),
    .o_q     (w_sync)
  );

  assign w_ul = w_sync[0];
  assign w_lk = MAX_STAGES'(w_sync[NUM_STAGES:1]);

  // Stages below the limit must already be locked; report the lowest one that is not.
  always_comb begin
    w_lost_lim = (r_state == RUN) ? 4'(NUM_STAGES) : {1'b0, r_stage};
    w_lost     = 1'b0;
    w_lost_idx = '0;
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      if (i < int'(w_lost_lim) && !w_lk[i]) begin
        w_lost     = 1'b1;
        w_lost_idx = 3'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_retry_nxt = r_retry;
    w_fault_nxt = r_fault;
    w_hold_nxt  = r_hold_cnt;
    w_tmo_nxt   = r_tmo_cnt;
    unique case (r_state)
      IDLE: begin
        w_stage_nxt = '0;
        w_tmo_nxt   = '0;
        if (!w_ul) begin
          w_hold_nxt = '0;
        end else if (r_hold_cnt >= HOLD_LAST) begin
          w_state_nxt = HOLD;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      HOLD, RELEASE, RUN: begin
        if (!w_ul) begin
          w_state_nxt = IDLE;
          w_stage_nxt = '0;
          w_retry_nxt = '0;
          w_hold_nxt  = '0;
          w_tmo_nxt   = '0;
        end else if (w_lost) begin
          w_state_nxt = HOLD;
          w_stage_nxt = w_lost_idx;
          w_retry_nxt = '0;
          w_hold_nxt  = '0;
          w_tmo_nxt   = '0;
        end else if (r_state == HOLD) begin
          if (r_hold_cnt >= HOLD_LAST) begin
            w_state_nxt = RELEASE;
            w_hold_nxt  = '0;
            w_tmo_nxt   = '0;
          end else begin
            w_hold_nxt = r_hold_cnt + HOLD_W'(1);
          end
        end else if (r_state == RELEASE) begin
          if (w_lk[r_stage]) begin
            w_retry_nxt = '0;
            w_hold_nxt  = '0;
            w_tmo_nxt   = '0;
            if (r_stage == LAST_STAGE) begin
              w_state_nxt = RUN;
            end else begin
              w_state_nxt = HOLD;
              w_stage_nxt = r_stage + 3'd1;
            end
          end else if (r_tmo_cnt >= TMO_LAST) begin
            w_hold_nxt = '0;
            w_tmo_nxt  = '0;
            if (r_retry >= RETRY_MAX) begin
              w_state_nxt = FAULT;
              w_fault_nxt = 1'b1;
            end else begin
              w_state_nxt = HOLD;
              w_retry_nxt = r_retry + RETRY_W'(1);
            end
          end else begin
            w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
          end
        end
      end
      FAULT: begin
        // Upstream lock is deliberately ignored here so the fault stays visible.
        if (clear_fault) begin
          w_state_nxt = IDLE;
          w_fault_nxt = 1'b0;
          w_retry_nxt = '0;
          w_stage_nxt = '0;
          w_hold_nxt  = '0;
          w_tmo_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_rst_nxt = '1;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_rst_nxt[i] = stage_in_reset(w_state_nxt, w_stage_nxt, i);
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_stage      <= '0;
      r_retry      <= '0;
      r_fault      <= 1'b0;
      r_all_locked <= 1'b0;
      r_mmcm_rst   <= '1;
      r_hold_cnt   <= '0;
      r_tmo_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_stage      <= w_stage_nxt;
      r_retry      <= w_retry_nxt;
      r_fault      <= w_fault_nxt;
      r_all_locked <= (w_state_nxt == RUN);
      r_mmcm_rst   <= w_rst_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
    end
  end

  assign mmcm_rst   = r_mmcm_rst;
  assign all_locked = r_all_locked;
  assign fault      = r_fault;
  assign stage_idx  = r_stage;
  assign retry_cnt  = r_retry;
  assign state      = r_state;

`ifdef MMCM_SEQ_LOSS_CNT_EN
  logic        w_loss_evt;
  logic [15:0] r_loss_cnt;

  // Upstream drops count in any active state; stage drops count only once fully up.
  assign w_loss_evt = (r_state == HOLD || r_state == RELEASE || r_state == RUN) &&
                      (!w_ul || (r_state == RUN && w_lost));

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && r_loss_cnt != 16'hFFFF) begin
      r_loss_cnt <= r_loss_cnt + 16'd1;
    end
  end

  assign loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_mmcm_seq_ctrl.sv
// Bench for mmcm_seq_ctrl: scenario table, randomized lock timing against an arithmetic
// timeline model, and directed loss / fault / reset sequences.
module tb_mmcm_seq_ctrl;

  localparam int N   = 2;
  localparam int HO  = 15;
  localparam int TMO = 200;
  localparam int MR  = 3;
  localparam int S_IDLE = 0, S_HOLD = 1, S_REL = 2, S_RUN = 3, S_FAULT = 4;

  logic         mclk            = 1'b0;
  logic         rst_n           = 1'b1;
  logic         upstream_locked = 1'b0;
  logic         clear_fault     = 1'b0;
  logic [N-1:0] locked_in       = '0;
  logic [N-1:0] mmcm_rst;
  logic         all_locked;
  logic         fault;
  logic [2:0]   stage_idx;
  logic [1:0]   retry_cnt;
  logic [2:0]   state;
`ifdef MMCM_SEQ_LOSS_CNT_EN
  logic [15:0]  loss_cnt;
`endif

  mmcm_seq_ctrl #(
    .NUM_STAGES     (N),
    .HOLDOFF_CYCLES (HO),
    .LOCK_TIMEOUT   (TMO),
    .MAX_RETRIES    (MR)
  ) dut (
    .mclk            (mclk),
    .rst_n           (rst_n),
    .upstream_locked (upstream_locked),
    .locked_in       (locked_in),
    .clear_fault     (clear_fault),
    .mmcm_rst        (mmcm_rst),
    .all_locked      (all_locked),
    .fault           (fault),
    .stage_idx       (stage_idx),
    .retry_cnt       (retry_cnt),
    .state           (state)
`ifdef MMCM_SEQ_LOSS_CNT_EN
    ,
    .loss_cnt        (loss_cnt)
`endif
  );

  always #5 mclk = ~mclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int dly[N], dead[N], lcnt[N], attempts[N];
  int last_fall[N];
  int run_edge, fault_edge;
  int rq[$];
  logic [N-1:0] prev_rst;

  typedef struct {
    int f0, f1, d0, d1;
    int e_fall0, e_fall1, e_end;
    int e_fault;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One mclk cycle: sample just after the edge, log events, then advance the MMCM models.
  task automatic step();
    @(posedge mclk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (prev_rst[k] && !mmcm_rst[k]) begin
        last_fall[k] = cyc;
        attempts[k]++;
        if (k == 1) rq.push_back(int'(retry_cnt));
      end
    end
    if (state == 3'(S_RUN) && run_edge < 0) run_edge = cyc;
    if (fault && fault_edge < 0) fault_edge = cyc;
    for (int k = 0; k < N; k++) begin
      if (mmcm_rst[k]) lcnt[k] = 0;
      else lcnt[k]++;
      locked_in[k] = !mmcm_rst[k] && lcnt[k] > dly[k] && attempts[k] > dead[k];
    end
    prev_rst = mmcm_rst;
  endtask

  task automatic do_reset(input int f0, input int f1, input int d0, input int d1);
    rst_n = 1'b0;
    upstream_locked = 1'b0;
    clear_fault = 1'b0;
    locked_in = '0;
    dead[0] = f0; dead[1] = f1; dly[0] = d0; dly[1] = d1;
    for (int k = 0; k < N; k++) begin
      lcnt[k] = 0; attempts[k] = 0; last_fall[k] = -1;
    end
    run_edge = -1; fault_edge = -1;
    rq.delete();
    prev_rst = '1;
    @(posedge mclk);
    #1;
    rst_n = 1'b1;
    upstream_locked = 1'b1;
    cyc = 0;
  endtask

  // Timeline from the sequencing rules: 2 sync cycles, HO qualifying cycles, HO holdoff per
  // attempt, TMO cycles per failed attempt, and lock seen 3 cycles after the raw rise.
  task automatic predict(input int f0, input int f1, input int d0, input int d1,
                         output int e_fall0, output int e_fall1, output int e_end,
                         output int e_fault);
    int f[N], d[N], fl[N];
    int t, fa;
    bit done;
    f[0] = f0; f[1] = f1; d[0] = d0; d[1] = d1;
    fl[0] = -1; fl[1] = -1;
    t = 2 + HO;
    e_fault = 0;
    done = 0;
    for (int k = 0; k < N && !done; k++) begin
      for (int a = 0; a <= MR && !done; a++) begin
        fa = t + HO;
        fl[k] = fa;
        if (a < f[k]) begin
          t = fa + TMO;
          if (a == MR) begin
            e_fault = 1;
            done = 1;
          end
        end else begin
          t = fa + d[k] + 3;
          a = MR + 1;
        end
      end
    end
    e_fall0 = fl[0];
    e_fall1 = fl[1];
    e_end = t;
  endtask

  task automatic run_scn(input vec_t v, input string nm);
    int n = 0;
    do_reset(v.f0, v.f1, v.d0, v.d1);
    while (run_edge < 0 && fault_edge < 0 && n < 4000) begin
      step();
      n++;
    end
    check({nm, "_fall0"}, last_fall[0], v.e_fall0);
    check({nm, "_fall1"}, last_fall[1], v.e_fall1);
    check({nm, "_end"}, v.e_fault ? fault_edge : run_edge, v.e_end);
    check({nm, "_fault"}, int'(fault), v.e_fault);
    check({nm, "_state"}, int'(state), v.e_fault ? S_FAULT : S_RUN);
    check({nm, "_all_locked"}, int'(all_locked), v.e_fault ? 0 : 1);
  endtask

  task automatic wait_state(input int st, input int stg, input int budget, input string nm);
    int n = 0;
    while (!(int'(state) == st && (stg < 0 || int'(stage_idx) == stg)) && n < budget) begin
      step();
      n++;
    end
    check(nm, (int'(state) == st && (stg < 0 || int'(stage_idx) == stg)) ? 1 : 0, 1);
  endtask

  task automatic drop_and_check(input logic [N-1:0] mask, input int exp_stage,
                                input int exp_rst, input string nm);
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
        lcnt[k] = 0;
        locked_in[k] = 1'b0;
      end
    end
    step(); step(); step();
    check({nm, "_state"}, int'(state), S_HOLD);
    check({nm, "_stage"}, int'(stage_idx), exp_stage);
    check({nm, "_rst"}, int'(mmcm_rst), exp_rst);
    check({nm, "_all_locked"}, int'(all_locked), 0);
  endtask

  initial begin
    vec_t tbl[3];
    vec_t rv;
    int r0;
    // Stage 0 is released after the upstream qualification window plus its own holdoff.
    tbl[0] = '{0, 0, 100, 100, 32, 150, 253, 0};
    tbl[1] = '{0, 4, 100, 100, 32, 795, 995, 1};
    tbl[2] = '{1, 0, 10, 50, 247, 275, 328, 0};

    cyc = 0;
    for (int k = 0; k < N; k++) begin
      dly[k] = 100; dead[k] = 0; lcnt[k] = 0; attempts[k] = 0; last_fall[k] = -1;
    end
    prev_rst = '1;
    #1 rst_n = 1'b0;
    @(posedge mclk);
    #1;
    check("rst_mmcm_rst", int'(mmcm_rst), 3);
    check("rst_all_locked", int'(all_locked), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_stage", int'(stage_idx), 0);
    check("rst_retry", int'(retry_cnt), 0);
    check("rst_state", int'(state), S_IDLE);

    for (int i = 0; i < 3; i++) run_scn(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 6; i++) begin
      rv.f0 = $urandom_range(0, 2);
      rv.f1 = ($urandom_range(0, 5) == 0) ? 4 : $urandom_range(0, 2);
      rv.d0 = $urandom_range(5, 190);
      rv.d1 = $urandom_range(5, 190);
      predict(rv.f0, rv.f1, rv.d0, rv.d1, rv.e_fall0, rv.e_fall1, rv.e_end, rv.e_fault);
      run_scn(rv, $sformatf("rnd%0d", i));
    end

    // Retry exhaustion on stage 1, then fault hold and clear.
    run_scn(tbl[1], "flt");
    check("flt_retry_seq_len", rq.size(), 4);
    for (int i = 0; i < rq.size(); i++) check($sformatf("flt_retry_at_rel%0d", i), rq[i], i);
    check("flt_rst", int'(mmcm_rst), 3);
    check("flt_retry", int'(retry_cnt), MR);
    upstream_locked = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("flt_hold_state", int'(state), S_FAULT);
    check("flt_hold_fault", int'(fault), 1);
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    check("clr_state", int'(state), S_IDLE);
    check("clr_fault", int'(fault), 0);
    check("clr_retry", int'(retry_cnt), 0);
    check("clr_rst", int'(mmcm_rst), 3);

    // RUN-state losses, then asynchronous reset in the middle of a holdoff.
    run_scn(tbl[0], "loss");
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    check("clr_ignored_state", int'(state), S_RUN);
    drop_and_check(2'b11, 0, 3, "drop_both");
    wait_state(S_RUN, -1, 600, "drop_both_reseq");
    check("drop_both_all_locked", int'(all_locked), 1);
    drop_and_check(2'b10, 1, 2, "drop_s1");
    wait_state(S_RUN, -1, 400, "drop_s1_reseq");
    drop_and_check(2'b01, 0, 3, "drop_s0");
`ifdef MMCM_SEQ_LOSS_CNT_EN
    check("loss_cnt_3", int'(loss_cnt), 3);
`endif
    step(); step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_rst", int'(mmcm_rst), 3);
    check("arst_state", int'(state), S_IDLE);
    check("arst_stage", int'(stage_idx), 0);
    check("arst_retry", int'(retry_cnt), 0);
    check("arst_fault", int'(fault), 0);
    check("arst_all_locked", int'(all_locked), 0);
`ifdef MMCM_SEQ_LOSS_CNT_EN
    check("arst_loss_cnt", int'(loss_cnt), 0);
`endif

    // Upstream loss while stage 1 is released.
    do_reset(0, 0, 100, 150);
    wait_state(S_REL, 1, 400, "ul_reach_rel1");
    for (int i = 0; i < 20; i++) step();
    upstream_locked = 1'b0;
    step(); step(); step();
    check("ul_state", int'(state), S_IDLE);
    check("ul_all_locked", int'(all_locked), 0);
    check("ul_rst", int'(mmcm_rst), 3);
    r0 = cyc;
    last_fall[0] = -1;
    upstream_locked = 1'b1;
    for (int n = 0; n < 100 && last_fall[0] < 0; n++) step();
    check("ul_refall0", last_fall[0], r0 + 2 + 2 * HO);
    wait_state(S_RUN, -1, 600, "ul_reseq_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
